// File: rtl/e_pow2_engine_if.sv
// Operand/result bus of the repeated-squaring engine: start/abort control in, status and result out.
// Word 0 of in_data/out_data is the least significant word.
interface e_pow2_engine_if #(
    parameter int WORDS  = 4,
    parameter int WORD_W = 16
);
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] in_data  [0:WORDS-1];
    logic              busy;
    logic              done;
    logic              ovf;
    logic [WORD_W-1:0] out_data [0:WORDS-1];

    modport master (
        output start, abort, in_data,
        input  busy, done, ovf, out_data
    );

    modport slave (
        input  start, abort, in_data,
        output busy, done, ovf, out_data
    );
endinterface

// File: rtl/e_pow2_engine.sv
// Raises an unsigned fixed-point operand to 2^ITERS by repeated squaring with one word product per cycle.
// Latency ITERS*(WORDS*WORDS+1) edges from start to done; start is ignored unless idle, abort cancels a run.
module e_pow2_engine #(
    parameter int WORDS      = 4,
    parameter int WORD_W     = 16,
    parameter int FRAC_WORDS = 2,
    parameter int ITERS      = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    e_pow2_engine_if.slave  bus
);
    localparam int OP_W  = WORDS * WORD_W;
    localparam int ACC_W = 2 * OP_W;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = $clog2(ITERS + 1);
    localparam int LO    = FRAC_WORDS * WORD_W;
    localparam int HI    = (FRAC_WORDS + WORDS) * WORD_W;

    typedef enum logic [1:0] {IDLE, MAC, NORM, DONE} state_t;

    state_t            state;
    logic [OP_W-1:0]   op;
    logic [ACC_W-1:0]  acc;
    logic [IW-1:0]     idx_i;
    logic [IW-1:0]     idx_j;
    logic [CW-1:0]     iter;
    logic              busy_r;
    logic              done_r;
    logic              ovf_r;
    logic [OP_W-1:0]   out_r;

    logic [OP_W-1:0]     in_flat;
    logic [WORD_W-1:0]   word_a;
    logic [WORD_W-1:0]   word_b;
    logic [2*WORD_W-1:0] prod;
    logic [ACC_W-1:0]    prod_sh;
    logic                high_nz;
    logic [OP_W-1:0]     norm_op;
    logic [CW-1:0]       iter_nxt;
    logic                last_j;
    logic                last_pair;

    always_comb begin
        in_flat = '0;
        for (int w = 0; w < WORDS; w++) begin
            in_flat[w*WORD_W +: WORD_W] = bus.in_data[w];
        end
    end

    assign word_a    = op[int'(idx_i)*WORD_W +: WORD_W];
    assign word_b    = op[int'(idx_j)*WORD_W +: WORD_W];
    assign prod      = (2*WORD_W)'(word_a) * (2*WORD_W)'(word_b);
    assign prod_sh   = ACC_W'(prod) << (WORD_W * (int'(idx_i) + int'(idx_j)));
    // Anything above the kept integer words means the square no longer fits: saturate.
    assign high_nz   = |acc[ACC_W-1:HI];
    assign norm_op   = high_nz ? '1 : acc[LO +: OP_W];
    assign iter_nxt  = iter + CW'(1);
    assign last_j    = (idx_j == IW'(WORDS - 1));
    assign last_pair = last_j && (idx_i == IW'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            acc    <= '0;
            idx_i  <= '0;
            idx_j  <= '0;
            iter   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
            out_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        op     <= in_flat;
                        acc    <= '0;
                        ovf_r  <= 1'b0;
                        iter   <= '0;
                        idx_i  <= '0;
                        idx_j  <= '0;
                        busy_r <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    if (bus.abort) begin
                        acc    <= '0;
                        idx_i  <= '0;
                        idx_j  <= '0;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        acc <= acc + prod_sh;
                        if (last_pair) begin
                            idx_i <= '0;
                            idx_j <= '0;
                            state <= NORM;
                        end else if (last_j) begin
                            idx_j <= '0;
                            idx_i <= idx_i + IW'(1);
                        end else begin
                            idx_j <= idx_j + IW'(1);
                        end
                    end
                end
                NORM: begin
                    acc <= '0;
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        op   <= norm_op;
                        iter <= iter_nxt;
                        if (high_nz) begin
                            ovf_r <= 1'b1;
                        end
                        if (iter_nxt == CW'(ITERS)) begin
                            out_r  <= norm_op;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= MAC;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.ovf  = ovf_r;

    for (genvar g = 0; g < WORDS; g++) begin : g_out
        assign bus.out_data[g] = out_r[g*WORD_W +: WORD_W];
    end
endmodule
